// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and duty (%) of a PWM input.
// Ports: clk, rst_n, pwm_in -> high_time, period, duty_pct, duty_valid,
//        busy, timeout, stuck_level, overrun.
module pwm_capture #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [6:0]       duty_pct,
  output logic             duty_valid,
  output logic             busy,
  output logic             timeout,
  output logic             stuck_level,
  output logic             overrun
);

  localparam int NUM_W = CNT_W + 7;
  localparam int IT_W  = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] P_MAX = '1;
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(NUM_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rd;
  logic                   w_fd;

  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_h_lat;

  logic w_to;
  logic w_cap;
  logic w_hld;

  logic             r_timeout;
  logic             r_stuck;
  logic             r_overrun;

  logic             r_busy;
  logic [IT_W-1:0]  r_iter;
  logic [NUM_W-1:0] r_num;
  logic [CNT_W-1:0] r_rem;
  logic [5:0]       r_q;
  logic [CNT_W-1:0] r_h_op;
  logic [CNT_W-1:0] r_p_op;

  logic [CNT_W:0]   w_trial;
  logic             w_ge;
  logic [CNT_W-1:0] w_sub;
  logic [6:0]       w_qn;
  logic             w_last;
  logic [NUM_W-1:0] w_num;

  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_period;
  logic [6:0]       r_duty;
  logic             r_valid;

  assign w_s  = r_sync[SYNC_STAGES-1];
  assign w_rd = w_s & ~r_s_d;
  assign w_fd = ~w_s & r_s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  // Saturating period counter; reads k in the k-th cycle after a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (w_rd) begin
      r_pcnt <= CNT_W'(1);
    end else if (r_pcnt != P_MAX) begin
      r_pcnt <= r_pcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_to) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_rd) w_state_nxt = S_HIGH;
        S_HIGH: if (w_fd) w_state_nxt = S_LOW;
        S_LOW:  if (w_rd) w_state_nxt = S_HIGH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_to  = 1'b0;
    w_cap = 1'b0;
    w_hld = 1'b0;
    if (r_state != S_IDLE) begin
      w_to = (r_pcnt == P_MAX) & ~w_rd;
    end
    w_cap = (r_state == S_LOW) & w_rd;
    w_hld = (r_state == S_HIGH) & w_fd & ~w_to;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_lat <= '0;
    end else if (w_hld) begin
      r_h_lat <= r_pcnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
      r_stuck   <= 1'b0;
    end else if (w_to) begin
      r_timeout <= 1'b1;
      r_stuck   <= w_s;
    end else if (w_rd) begin
      r_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_cap & r_busy) begin
      r_overrun <= 1'b1;
    end
  end

  // Restoring divider step. Remainder stays below the divisor, so
  // CNT_W bits hold it and the subtraction can wrap in CNT_W bits.
  // The quotient never exceeds 99, so only its low 7 bits are kept.
  assign w_num   = NUM_W'(r_h_lat) * NUM_W'(100);
  assign w_trial = {r_rem, r_num[NUM_W-1]};
  assign w_ge    = w_trial >= {1'b0, r_p_op};
  assign w_sub   = w_trial[CNT_W-1:0] - r_p_op;
  assign w_qn    = {r_q, w_ge};
  assign w_last  = r_iter == IT_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_iter <= '0;
      r_num  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_h_op <= '0;
      r_p_op <= '0;
    end else if (r_busy) begin
      r_busy <= ~w_last;
      r_iter <= r_iter + IT_W'(1);
      r_num  <= {r_num[NUM_W-2:0], 1'b0};
      r_rem  <= w_ge ? w_sub : w_trial[CNT_W-1:0];
      r_q    <= w_qn[5:0];
    end else if (w_cap) begin
      r_busy <= 1'b1;
      r_iter <= '0;
      r_num  <= w_num;
      r_rem  <= '0;
      r_q    <= '0;
      r_h_op <= r_h_lat;
      r_p_op <= r_pcnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_time <= '0;
      r_period    <= '0;
      r_duty      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= r_busy & w_last;
      if (r_busy & w_last) begin
        r_high_time <= r_h_op;
        r_period    <= r_p_op;
        r_duty      <= w_qn;
      end
    end
  end

  assign high_time   = r_high_time;
  assign period      = r_period;
  assign duty_pct    = r_duty;
  assign duty_valid  = r_valid;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign stuck_level = r_stuck;
  assign overrun     = r_overrun;

endmodule
